dft_in_framer: RTL

DFT_IN_FRAMER -- requirements
Module: dft_in_framer

---
 rtl/dft_in_framer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dft_in_framer.sv
// Input framer for the DFT engine: collects one block of complex samples into a
// ping-pong buffer. Optional idle-gap abort is enabled by defining GAP_TIMEOUT_EN.
module dft_in_framer #(
  parameter int DATA_W  = 16,
  parameter int TMO_CYC = 64
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys,
  input  logic                  block_sync_i,
  input  logic                  data_val_i,
  input  logic [DATA_W-1:0]     data_real_i,
  input  logic [DATA_W-1:0]     data_imag_i,
  input  logic [11:0]           trans_len_i,
  output logic                  wr_en_o,
  output logic [11:0]           wr_addr_o,
  output logic [2*DATA_W-1:0]   wr_data_o,
  output logic                  frame_done_o,
  output logic [11:0]           frame_len_o,
  output logic                  frame_err_o,
  output logic [1:0]            err_code_o,
  output logic [7:0]            drop_cnt_o,
  output logic                  busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MIN_SYM = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LEN   = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  // Symmetric range: the most negative code would have no positive counterpart.
  function automatic logic [DATA_W-1:0] clip_sym(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    if (x == MIN_NEG) begin
      y = MIN_SYM;
    end else begin
      y = x;
    end
    return y;
  endfunction

  state_t            state_r;
  state_t            state_nx_s;
  logic [10:0]       cnt_r;
  logic [10:0]       cnt_nx_s;
  logic              bank_r;
  logic              bank_nx_s;
  logic [11:0]       len_r;
  logic [11:0]       len_nx_s;
  logic [7:0]        drop_nx_s;
  logic              wr_en_nx_s;
  logic [11:0]       wr_addr_nx_s;
  logic [2*DATA_W-1:0] wr_data_nx_s;
  logic              done_nx_s;
  logic [11:0]       flen_nx_s;
  logic              err_nx_s;
  logic [1:0]        code_nx_s;

  logic              sync_s;
  logic              samp_s;
  logic              len_ok_s;
  logic              last_s;
  logic              tmo_s;
  logic [2*DATA_W-1:0] clip_data_s;

  assign sync_s      = data_val_i & block_sync_i;
  assign samp_s      = data_val_i & ~block_sync_i;
  assign len_ok_s    = (trans_len_i >= 12'd12) && (trans_len_i <= 12'd2048);
  assign last_s      = ({1'b0, cnt_r} == (len_r - 12'd1));
  assign clip_data_s = {clip_sym(data_real_i), clip_sym(data_imag_i)};

`ifdef GAP_TIMEOUT_EN
  localparam int GAP_W = $clog2(TMO_CYC + 1);
  logic [GAP_W-1:0] gap_r;

  // Consecutive idle cycles while collecting; cleared by any valid or outside COLLECT.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      gap_r <= '0;
    end else if ((state_r != ST_COLLECT) || data_val_i) begin
      gap_r <= '0;
    end else begin
      gap_r <= gap_r + GAP_W'(1);
    end
  end

  assign tmo_s = (state_r == ST_COLLECT) && !data_val_i && (gap_r == GAP_W'(TMO_CYC - 1));
`else
  assign tmo_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sync_s && len_ok_s) begin
          state_nx_s = ST_COLLECT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (sync_s) begin
          state_nx_s = len_ok_s ? ST_COLLECT : ST_IDLE;
        end else if (samp_s && last_s) begin
          state_nx_s = ST_IDLE;
        end else if (tmo_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_COLLECT;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Datapath and output next values; a sync always restarts at index 0 in the current bank.
  always_comb begin
    cnt_nx_s     = cnt_r;
    bank_nx_s    = bank_r;
    len_nx_s     = len_r;
    drop_nx_s    = drop_cnt_o;
    wr_en_nx_s   = 1'b0;
    wr_addr_nx_s = 12'd0;
    wr_data_nx_s = '0;
    done_nx_s    = 1'b0;
    flen_nx_s    = 12'd0;
    err_nx_s     = 1'b0;
    code_nx_s    = ERR_NONE;
    case (state_r)
      ST_IDLE: begin
        if (sync_s) begin
          if (len_ok_s) begin
            wr_en_nx_s   = 1'b1;
            wr_addr_nx_s = {bank_r, 11'd0};
            wr_data_nx_s = clip_data_s;
            cnt_nx_s     = 11'd1;
            len_nx_s     = trans_len_i;
          end else begin
            err_nx_s  = 1'b1;
            code_nx_s = ERR_LEN;
          end
        end else if (samp_s) begin
          if (drop_cnt_o != 8'hFF) begin
            drop_nx_s = drop_cnt_o + 8'd1;
          end else begin
            drop_nx_s = drop_cnt_o;
          end
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      ST_COLLECT: begin
        if (sync_s) begin
          err_nx_s  = 1'b1;
          code_nx_s = ERR_SHORT;
          if (len_ok_s) begin
            wr_en_nx_s   = 1'b1;
            wr_addr_nx_s = {bank_r, 11'd0};
            wr_data_nx_s = clip_data_s;
            cnt_nx_s     = 11'd1;
            len_nx_s     = trans_len_i;
          end else begin
            cnt_nx_s = 11'd0;
          end
        end else if (samp_s) begin
          wr_en_nx_s   = 1'b1;
          wr_addr_nx_s = {bank_r, cnt_r};
          wr_data_nx_s = clip_data_s;
          if (last_s) begin
            done_nx_s = 1'b1;
            flen_nx_s = len_r;
            bank_nx_s = ~bank_r;
            cnt_nx_s  = 11'd0;
          end else begin
            cnt_nx_s = cnt_r + 11'd1;
          end
        end else if (tmo_s) begin
          err_nx_s  = 1'b1;
          code_nx_s = ERR_TMO;
          cnt_nx_s  = 11'd0;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      default: begin
        cnt_nx_s = 11'd0;
      end
    endcase
  end

  // Registered datapath state and outputs.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      cnt_r        <= 11'd0;
      bank_r       <= 1'b0;
      len_r        <= 12'd0;
      drop_cnt_o   <= 8'd0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= 12'd0;
      wr_data_o    <= '0;
      frame_done_o <= 1'b0;
      frame_len_o  <= 12'd0;
      frame_err_o  <= 1'b0;
      err_code_o   <= ERR_NONE;
      busy_o       <= 1'b0;
    end else begin
      cnt_r        <= cnt_nx_s;
      bank_r       <= bank_nx_s;
      len_r        <= len_nx_s;
      drop_cnt_o   <= drop_nx_s;
      wr_en_o      <= wr_en_nx_s;
      wr_addr_o    <= wr_addr_nx_s;
      wr_data_o    <= wr_data_nx_s;
      frame_done_o <= done_nx_s;
      frame_len_o  <= flen_nx_s;
      frame_err_o  <= err_nx_s;
      err_code_o   <= code_nx_s;
      busy_o       <= (state_nx_s == ST_COLLECT);
    end
  end

endmodule
